// File: rtl/bank_mapper_pkg.sv
// Shared constants and types for the SPC7110-style bank mapper.
// Holds the region constants, the register-map default and the translation payload.
package bank_mapper_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WSEL_MSB  = 21;
  localparam int unsigned SPAN_BITS = 22;

  localparam logic [ADDR_W-1:0] SRAM_BASE    = 24'hE00000;
  localparam logic [15:0]       REG_BASE_DEF = 16'h4831;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_SRAM,
    RGN_PROM,
    RGN_DROM
  } region_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              sram;
  } xlate_t;

  // Banks 30-3F/B0-BF with offset 6000-7FFF
  function automatic logic in_sram_window(input logic [ADDR_W-1:0] a);
    return (a[22:20] == 3'b011) && (a[15:13] == 3'b011);
  endfunction

endpackage

// File: rtl/bank_mapper_regfile.sv
// Staged and live bank / SRAM-enable registers with commit and readback.
// Live values only change on a cycle-end commit; readback never exposes staged data.
module bank_mapper_regfile
  import bank_mapper_pkg::*;
#(
  parameter int unsigned NUM_WIN = 3,
  parameter int unsigned BANK_W  = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      reg_hit_i,
  input  logic [IDX_W-1:0]          reg_idx_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      wr_stb_i,
  input  logic                      rd_stb_i,
  input  logic                      cycle_end_i,
  output logic [NUM_WIN*BANK_W-1:0] bank_live_o,
  output logic                      sram_en_o,
  output logic [DATA_W-1:0]         reg_dout_o,
  output logic                      reg_dout_en_o
);

  typedef logic [NUM_WIN-1:0][BANK_W-1:0] banks_t;

  function automatic banks_t reset_banks();
    banks_t r;
    for (int unsigned i = 0; i < NUM_WIN; i++) r[i] = BANK_W'(i);
    return r;
  endfunction

  localparam banks_t RST_BANKS = reset_banks();

  banks_t              stg_q, stg_d, live_q, live_d;
  logic                sram_stg_q, sram_stg_d, sram_live_q, sram_live_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_en_q, dout_en_d;

  always_comb begin
    stg_d       = stg_q;
    sram_stg_d  = sram_stg_q;
    live_d      = live_q;
    sram_live_d = sram_live_q;
    dout_d      = dout_q;
    dout_en_d   = 1'b0;

    if (wr_stb_i && reg_hit_i) begin
      if (32'(reg_idx_i) == NUM_WIN) sram_stg_d = wdata_i[DATA_W-1];
      for (int unsigned i = 0; i < NUM_WIN; i++)
        if (32'(reg_idx_i) == i) stg_d[i] = BANK_W'(wdata_i);
    end

    // Commit takes the post-write staged view so a coincident write lands directly
    if (cycle_end_i) begin
      live_d      = stg_d;
      sram_live_d = sram_stg_d;
    end

    if (rd_stb_i && reg_hit_i) begin
      dout_en_d = 1'b1;
      dout_d    = '0;
      if (32'(reg_idx_i) == NUM_WIN) dout_d = {sram_live_q, {(DATA_W-1){1'b0}}};
      for (int unsigned i = 0; i < NUM_WIN; i++)
        if (32'(reg_idx_i) == i) dout_d = DATA_W'(live_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stg_q       <= RST_BANKS;
      live_q      <= RST_BANKS;
      sram_stg_q  <= 1'b0;
      sram_live_q <= 1'b0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
    end else begin
      stg_q       <= stg_d;
      live_q      <= live_d;
      sram_stg_q  <= sram_stg_d;
      sram_live_q <= sram_live_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
    end
  end

  assign bank_live_o   = live_q;
  assign sram_en_o     = sram_live_q;
  assign reg_dout_o    = dout_q;
  assign reg_dout_en_o = dout_en_q;

endmodule

// File: rtl/bank_mapper.sv
// Bank-switch address mapper: register decode, SNES-to-ROM/SRAM translation and
// the output pipeline register; bank state lives in bank_mapper_regfile.
module bank_mapper
  import bank_mapper_pkg::*;
#(
  parameter int unsigned NUM_WIN  = 3,
  parameter int unsigned WIN_BITS = 2,
  parameter int unsigned BANK_W   = 3,
  parameter logic [15:0] REG_BASE = REG_BASE_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [ADDR_W-1:0]         SNES_ADDR,
  input  logic [DATA_W-1:0]         SNES_DATA_IN,
  input  logic                      SNES_ADDR_STB,
  input  logic                      SNES_WR_STB,
  input  logic                      SNES_RD_STB,
  input  logic                      SNES_CYCLE_END,
  input  logic [ADDR_W-1:0]         ROM_MASK,
  input  logic [ADDR_W-1:0]         SAVERAM_MASK,
  output logic [ADDR_W-1:0]         ROM_ADDR,
  output logic                      ROM_ADDR_VLD,
  output logic                      ROM_HIT,
  output logic                      IS_SAVERAM,
  output logic [DATA_W-1:0]         REG_DOUT,
  output logic                      REG_DOUT_EN,
  output logic [NUM_WIN*BANK_W-1:0] BANK_LIVE,
  output logic                      SRAM_EN
);

  localparam int unsigned OFF_W    = SPAN_BITS - WIN_BITS;
  localparam int unsigned BLK_W    = BANK_W + 1;
  localparam int unsigned IDX_W    = $clog2(NUM_WIN + 1);
  localparam logic [15:0] REG_LAST = REG_BASE + 16'(NUM_WIN);

  logic [WIN_BITS-1:0]       win_sel;
  logic [OFF_W-1:0]          win_off;
  logic                      reg_hit;
  logic [IDX_W-1:0]          reg_idx;
  logic [NUM_WIN*BANK_W-1:0] bank_live;
  logic                      sram_en;
  logic [BANK_W-1:0]         bank_sel;
  logic [BLK_W-1:0]          blk;
  region_e                   region;
  xlate_t                    xl_new, xl_d, xl_q;
  logic                      vld_d, vld_q;

  assign win_sel = SNES_ADDR[WSEL_MSB -: WIN_BITS];
  assign win_off = SNES_ADDR[OFF_W-1:0];
  assign reg_hit = !SNES_ADDR[22] && (SNES_ADDR[15:0] >= REG_BASE) && (SNES_ADDR[15:0] <= REG_LAST);
  assign reg_idx = IDX_W'(SNES_ADDR[15:0] - REG_BASE);

  bank_mapper_regfile #(
    .NUM_WIN (NUM_WIN),
    .BANK_W  (BANK_W),
    .IDX_W   (IDX_W)
  ) u_regfile (
    .clk_i         (CLK),
    .rst_n_i       (RST_N),
    .reg_hit_i     (reg_hit),
    .reg_idx_i     (reg_idx),
    .wdata_i       (SNES_DATA_IN),
    .wr_stb_i      (SNES_WR_STB),
    .rd_stb_i      (SNES_RD_STB),
    .cycle_end_i   (SNES_CYCLE_END),
    .bank_live_o   (bank_live),
    .sram_en_o     (sram_en),
    .reg_dout_o    (REG_DOUT),
    .reg_dout_en_o (REG_DOUT_EN)
  );

  // Region classification and translation from the pre-commit live registers
  always_comb begin
    bank_sel = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++)
      if (32'(win_sel) == i + 1) bank_sel = bank_live[i*BANK_W +: BANK_W];
    blk = {1'b0, bank_sel} + BLK_W'(1);

    region = RGN_NONE;
    if (in_sram_window(SNES_ADDR) && sram_en && SAVERAM_MASK[0]) begin
      region = RGN_SRAM;
    end else if (SNES_ADDR[23:22] == 2'b11) begin
      if (win_sel == '0)                 region = RGN_PROM;
      else if (32'(win_sel) <= NUM_WIN)  region = RGN_DROM;
    end

    xl_new = '0;
    case (region)
      RGN_SRAM: begin
        xl_new.addr = SRAM_BASE + (ADDR_W'({SNES_ADDR[20:16], SNES_ADDR[12:0]}) & SAVERAM_MASK);
        xl_new.hit  = 1'b1;
        xl_new.sram = 1'b1;
      end
      RGN_PROM: begin
        xl_new.addr = ADDR_W'(win_off) & ROM_MASK;
        xl_new.hit  = 1'b1;
      end
      RGN_DROM: begin
        xl_new.addr = ADDR_W'({blk, win_off}) & ROM_MASK;
        xl_new.hit  = 1'b1;
      end
      default: xl_new = '0;
    endcase

    xl_d  = xl_q;
    vld_d = 1'b0;
    if (SNES_ADDR_STB) begin
      xl_d  = xl_new;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      xl_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      xl_q  <= xl_d;
      vld_q <= vld_d;
    end
  end

  assign ROM_ADDR     = xl_q.addr;
  assign ROM_HIT      = xl_q.hit;
  assign IS_SAVERAM   = xl_q.sram;
  assign ROM_ADDR_VLD = vld_q;
  assign BANK_LIVE    = bank_live;
  assign SRAM_EN      = sram_en;

endmodule
